// File: rtl/defunnel_pkg.sv
// Shared types and constants for the 3:1 defunnel scheduler.
package defunnel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } state_e;

  localparam logic [7:0] MODE_1LANE = 8'h01;
  localparam logic [7:0] MODE_2LANE = 8'h02;

  // Config word layout: {words, mode}
  localparam int unsigned CFG_MODE_LSB  = 0;
  localparam int unsigned CFG_MODE_W    = 8;
  localparam int unsigned CFG_WORDS_LSB = 8;

  // Lanes consumed per beat for a mode's low bits; 0 marks an illegal mode.
  function automatic logic [1:0] lanes_per_beat(input logic [1:0] mode_lo);
    logic [1:0] lanes;
    lanes = 2'd0;
    if (mode_lo == MODE_1LANE[1:0]) lanes = 2'd1;
    if (mode_lo == MODE_2LANE[1:0]) lanes = 2'd2;
    return lanes;
  endfunction

endpackage

// File: rtl/defunnel_sched_3_1_if.sv
// Handshake bundle between the lane sources, the defunnel and the scheduler.
// master: environment side; slave: scheduler side.
interface defunnel_sched_3_1_if #(
  parameter int unsigned CNT_W = 8
);
  logic             t_cfg_req;
  logic             t_cfg_ack;
  logic [CNT_W+7:0] t_cfg_dat;
  logic             t_0_req;
  logic             t_0_ack;
  logic             t_1_req;
  logic             t_1_ack;
  logic             i_0_req;
  logic             i_0_ack;
  logic             i_1_req;
  logic             i_1_ack;
  logic             w_req;
  logic             w_ack;
  logic [7:0]       mode;
  logic             busy;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output t_cfg_req, t_cfg_dat, t_0_req, t_1_req, i_0_ack, i_1_ack, w_req, w_ack,
    input  t_cfg_ack, t_0_ack, t_1_ack, i_0_req, i_1_req, mode, busy, cfg_done, cfg_err
  );

  modport slave (
    input  t_cfg_req, t_cfg_dat, t_0_req, t_1_req, i_0_ack, i_1_ack, w_req, w_ack,
    output t_cfg_ack, t_0_ack, t_1_ack, i_0_req, i_1_req, mode, busy, cfg_done, cfg_err
  );

endinterface

// File: rtl/defunnel_cfg_fifo.sv
// Config command FIFO with registered ready (not-full) and empty flags.
// Ready resets low so nothing is accepted during or at reset.
module defunnel_cfg_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             ready_q, empty_q;
  logic             push, pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push = push_i & ready_q;
  assign pop  = pop_i & ~empty_q;

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PtrW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (PtrW+1)'(1);
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != CntFull);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array; contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/defunnel_sched_3_1.sv
// Sequencer for the 3:1 defunnel: queues {words, mode} commands, gates source
// lanes so each command feeds exactly words*4 lanes, then waits for the output
// words to drain before releasing the mode.
// Optional DEFUNNEL_SCHED_PERF_EN adds a saturating lane-0 stall counter.
module defunnel_sched_3_1
  import defunnel_pkg::*;
#(
  parameter int unsigned CFG_DEPTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  defunnel_sched_3_1_if.slave  bus
`ifdef DEFUNNEL_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_stall
`endif
);

  localparam int unsigned CfgW  = CNT_W + 8;
  localparam int unsigned BeatW = CNT_W + 2;

  state_e             state_q, state_d;
  logic [CfgW-1:0]    head_q, head_d;
  logic [7:0]         mode_q, mode_d;
  logic [BeatW-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               fifo_ready, fifo_empty, fifo_pop;
  logic [CfgW-1:0]    fifo_head;

  logic [7:0]         head_mode;
  logic [CNT_W-1:0]   head_words;
  logic [1:0]         head_lanes;
  logic               two_lane, word_hs, beat;
  logic               i0_req, i1_req, t0_ack, t1_ack, done, err;

  defunnel_cfg_fifo #(
    .Depth (CFG_DEPTH),
    .Width (CfgW)
  ) u_cfg_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (bus.t_cfg_req),
    .data_i  (bus.t_cfg_dat),
    .ready_o (fifo_ready),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  assign head_mode  = head_q[CFG_MODE_LSB +: CFG_MODE_W];
  assign head_words = head_q[CFG_WORDS_LSB +: CNT_W];
  assign head_lanes = lanes_per_beat(head_mode[1:0]);
  assign two_lane   = (mode_q[1:0] == MODE_2LANE[1:0]);
  assign word_hs    = bus.w_req & bus.w_ack;
  assign beat       = bus.t_0_req & bus.i_0_ack & (~two_lane | (bus.t_1_req & bus.i_1_ack));

  // FSM next-state, counters and combinational lane gating.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    mode_d   = mode_q;
    beats_d  = beats_q;
    words_d  = words_q;
    fifo_pop = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    i0_req   = 1'b0;
    i1_req   = 1'b0;
    t0_ack   = 1'b0;
    t1_ack   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          head_d   = fifo_head;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (head_lanes == 2'd0) begin
          err     = 1'b1;
          state_d = StIdle;
        end else if (head_words == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          mode_d  = head_mode;
          words_d = head_words;
          // words*4 lanes spread over 1 or 2 lanes per beat
          beats_d = (head_lanes == 2'd1) ? {head_words, 2'b00} : {1'b0, head_words, 1'b0};
          state_d = StRun;
        end
      end
      StRun: begin
        i0_req = bus.t_0_req;
        t0_ack = bus.i_0_ack;
        if (two_lane) begin
          i1_req = bus.t_1_req;
          t1_ack = bus.i_1_ack;
        end
        if (word_hs && (words_q != '0)) words_d = words_q - CNT_W'(1);
        if (beat) begin
          beats_d = beats_q - BeatW'(1);
          if (beats_q == BeatW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (words_q == '0) begin
          done    = 1'b1;
          mode_d  = '0;
          state_d = StIdle;
        end else if (word_hs) begin
          words_d = words_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      head_q  <= '0;
      mode_q  <= '0;
      beats_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      mode_q  <= mode_d;
      beats_q <= beats_d;
      words_q <= words_d;
    end
  end

  assign bus.t_cfg_ack = fifo_ready;
  assign bus.i_0_req   = i0_req;
  assign bus.i_1_req   = i1_req;
  assign bus.t_0_ack   = t0_ack;
  assign bus.t_1_ack   = t1_ack;
  assign bus.mode      = mode_q;
  assign bus.busy      = (state_q != StIdle) | ~fifo_empty;
  assign bus.cfg_done  = done;
  assign bus.cfg_err   = err;

`ifdef DEFUNNEL_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Count RUN cycles where lane 0 offers data but is not accepted; saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if ((state_q == StRun) && bus.t_0_req && !t0_ack && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall = perf_q;
`endif

endmodule
